// File: rtl/ext_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// ext_mem_arb_pkg
// Shared types and constants for the two-master external memory arbiter:
//   arb_state_t        - sequencer states (IDLE, ISSUE, WAIT, RESP)
//   MASTERS            - number of requesting masters
//   ERR_RDATA_DEFAULT  - read data handed back when an access times out
// ----------------------------------------------------------------------------
package ext_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int MASTERS = 2;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hdead_beef;

endpackage

// File: rtl/ext_mem_rr_arb2.sv
// ----------------------------------------------------------------------------
// ext_mem_rr_arb2
// Combinational two-input round-robin grant.
//   req_i        - request vector, bit i = master i
//   last_grant_i - index of the master granted most recently
//   grant_o      - one-hot grant, or zero when nobody requests
// A lone requester always wins; on a tie the master that was not granted
// last time wins.
// ----------------------------------------------------------------------------
module ext_mem_rr_arb2
    import ext_mem_arb_pkg::*;
(
    input  logic [MASTERS-1:0] req_i,
    input  logic               last_grant_i,
    output logic [MASTERS-1:0] grant_o
);

    // Grant decode from the request pattern and the previous winner
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                if (last_grant_i) begin
                    grant_o = 2'b01;
                end else begin
                    grant_o = 2'b10;
                end
            end
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ext_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ext_mem_arbiter
// Shares one synchronous-read, byte-enabled external memory port between
// master 0 (core LSU) and master 1 (DMA/loader).
//   clk_i, rst_i              - clock, synchronous active-high reset
//   mN_req_i/we_i/be_i/addr_i/wdata_i - master N request and fields
//   mN_rdata_o/ready_o/err_o  - master N one-cycle completion (registered)
//   mem_req_o/we_o/be_o/addr_o/wdata_o - memory request, decoded from state
//   mem_rdata_i, mem_ready_i  - memory response
// The winner's fields are latched in IDLE, presented for ISSUE and every
// WAIT cycle, and the response is returned as a single ready pulse in RESP.
// An access that sees no mem_ready_i for TIMEOUT_CYCLES WAIT cycles completes
// with ERR_RDATA and err set.
// ----------------------------------------------------------------------------
module ext_mem_arbiter
    import ext_mem_arb_pkg::*;
#(
    parameter int unsigned  TIMEOUT_CYCLES = 16,
    parameter logic [31:0]  ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ready_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ready_o,
    output logic        m1_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    // Counter only needs to reach TIMEOUT_CYCLES-1
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state_q,      state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q,      owner_d;
    logic               we_q,         we_d;
    logic [3:0]         be_q,         be_d;
    logic [31:0]        addr_q,       addr_d;
    logic [31:0]        wdata_q,      wdata_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [1:0]         ready_q,      ready_d;
    logic [1:0]         err_q,        err_d;
    logic [31:0]        rdata0_q,     rdata0_d;
    logic [31:0]        rdata1_q,     rdata1_d;

    logic [MASTERS-1:0] grant_s;
    logic               done_s;
    logic [31:0]        res_rdata_s;
    logic               res_err_s;
    logic               mem_active_s;

    ext_mem_rr_arb2 u_rr_arb (
        .req_i        ({m1_req_i, m0_req_i}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s)
    );

    // Sequencer next state, winner latch, timeout count and completion data
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        done_s       = 1'b0;
        res_rdata_s  = 32'd0;
        res_err_s    = 1'b0;
        ready_d      = 2'b00;
        err_d        = 2'b00;
        rdata0_d     = 32'd0;
        rdata1_d     = 32'd0;

        case (state_q)
            IDLE: begin
                if (grant_s[1]) begin
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    we_d         = m1_we_i;
                    be_d         = m1_be_i;
                    addr_d       = m1_addr_i;
                    wdata_d      = m1_wdata_i;
                    state_d      = ISSUE;
                end else if (grant_s[0]) begin
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    we_d         = m0_we_i;
                    be_d         = m0_be_i;
                    addr_d       = m0_addr_i;
                    wdata_d      = m0_wdata_i;
                    state_d      = ISSUE;
                end else begin
                    state_d      = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = WAIT;
            end
            WAIT: begin
                // A ready in the last allowed cycle still wins over the timeout
                if (mem_ready_i) begin
                    done_s      = 1'b1;
                    res_rdata_s = we_q ? 32'd0 : mem_rdata_i;
                    res_err_s   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    done_s      = 1'b1;
                    res_rdata_s = ERR_RDATA;
                    res_err_s   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion is registered so the pulse appears during RESP
        if (done_s) begin
            if (owner_q) begin
                ready_d[1] = 1'b1;
                err_d[1]   = res_err_s;
                rdata1_d   = res_rdata_s;
            end else begin
                ready_d[0] = 1'b1;
                err_d[0]   = res_err_s;
                rdata0_d   = res_rdata_s;
            end
        end else begin
            ready_d = 2'b00;
        end
    end

    // State, latched fields and master-side output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            cnt_q        <= {CNT_W{1'b0}};
            ready_q      <= 2'b00;
            err_q        <= 2'b00;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Memory side follows the state: the request is held through WAIT
    // because read data is only valid while it stays asserted
    assign mem_active_s = (state_q == ISSUE) || (state_q == WAIT);
    assign mem_req_o    = mem_active_s;
    assign mem_we_o     = mem_active_s & we_q;
    assign mem_be_o     = mem_active_s ? be_q    : 4'd0;
    assign mem_addr_o   = mem_active_s ? addr_q  : 32'd0;
    assign mem_wdata_o  = mem_active_s ? wdata_q : 32'd0;

    assign m0_ready_o   = ready_q[0];
    assign m0_err_o     = err_q[0];
    assign m0_rdata_o   = rdata0_q;
    assign m1_ready_o   = ready_q[1];
    assign m1_err_o     = err_q[1];
    assign m1_rdata_o   = rdata1_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ext_mem_arbiter
// Transaction-level reference: each access is described by its grant cycle,
// its memory latency and the resulting completion cycle; expected read data
// comes from a reference memory updated from the masters' own write intent,
// while a separate environment memory is written only through mem_* outputs.
// ----------------------------------------------------------------------------
module tb_ext_mem_arbiter;

    localparam int          TO    = 16;
    localparam logic [31:0] ERR   = 32'hdead_beef;
    localparam int          NEVER = 1000;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m0_ready_o, m0_err_o;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic        m1_req_i, m1_we_i, m1_ready_o, m1_err_o;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    always #5 clk_i = ~clk_i;

    ext_mem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // reference model state
    txn_t pend [2];
    bit   pend_v [2];
    bit   busy;
    int   owner, g_cyc, r_cyc, idle_from, cur_lat, last, hi_cnt;
    bit   cur_to;
    txn_t cur;

    // stimulus controls
    int auto_rate, withdraw_rate, lat_force;
    bit scramble, rst_drive, checks_on;

    // DUT observations
    int          rdy_log [$];
    int          last_rdy_cyc [2];
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    int          req_hi_total;
    txn_t        seen;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9e37_79b9) ^ 32'h0bad_f00d;
    endfunction

    function automatic logic [31:0] rd_env(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[k*8 +: 8] = {8{be[k]}};
        return (old & ~m) | (wd & m);
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.be    = 4'($urandom_range(0, 15));
        t.addr  = 32'($urandom_range(0, 15)) << 2;
        t.wdata = $urandom;
        return t;
    endfunction

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70)      return int'($urandom_range(0, 3));
        else if (r < 85) return int'($urandom_range(4, 14));
        else if (r < 93) return TO - 1;
        else             return TO + int'($urandom_range(0, 4));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive_m(input int i, input logic req, input txn_t t);
        if (i == 0) begin
            m0_req_i = req; m0_we_i = t.we; m0_be_i = t.be; m0_addr_i = t.addr; m0_wdata_i = t.wdata;
        end else begin
            m1_req_i = req; m1_we_i = t.we; m1_be_i = t.be; m1_addr_i = t.addr; m1_wdata_i = t.wdata;
        end
    endtask

    task automatic issue(input int m, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        pend_v[m] = 1'b1;
        pend[m]   = {we, be, addr, wd};
    endtask

    // One clock: observe and check, answer as memory, drive masters, grant
    task automatic cycle();
        logic        act, exp_rdy, obs_rdy, obs_err;
        logic [31:0] exp_rd, obs_rd;
        int          n_wait, w;
        @(negedge clk_i);
        cyc++;

        if (mem_req_o === 1'b1) begin
            req_hi_total++;
            seen = {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
        end
        if (m0_ready_o === 1'b1) begin
            rdy_log.push_back(0); last_rdy_cyc[0] = cyc; last_rdata[0] = m0_rdata_o; last_err[0] = m0_err_o;
        end
        if (m1_ready_o === 1'b1) begin
            rdy_log.push_back(1); last_rdy_cyc[1] = cyc; last_rdata[1] = m1_rdata_o; last_err[1] = m1_err_o;
        end

        if (checks_on) begin
            act = busy && (cyc > g_cyc) && (cyc < r_cyc);
            chk("mem_req",   32'(mem_req_o), 32'(act));
            chk("mem_we",    32'(mem_we_o),  32'(act && cur.we));
            chk("mem_be",    32'(mem_be_o),  act ? 32'(cur.be) : 32'd0);
            chk("mem_addr",  mem_addr_o,     act ? cur.addr    : 32'd0);
            chk("mem_wdata", mem_wdata_o,    act ? cur.wdata   : 32'd0);
            for (int i = 0; i < 2; i++) begin
                exp_rdy = busy && (cyc == r_cyc) && (owner == i);
                if (!exp_rdy)    exp_rd = 32'd0;
                else if (cur_to) exp_rd = ERR;
                else if (cur.we) exp_rd = 32'd0;
                else             exp_rd = rd_ref(cur.addr);
                obs_rdy = (i == 0) ? m0_ready_o : m1_ready_o;
                obs_err = (i == 0) ? m0_err_o   : m1_err_o;
                obs_rd  = (i == 0) ? m0_rdata_o : m1_rdata_o;
                chk($sformatf("m%0d_ready", i), 32'(obs_rdy), 32'(exp_rdy));
                chk($sformatf("m%0d_err", i),   32'(obs_err), 32'(exp_rdy && cur_to));
                chk($sformatf("m%0d_rdata", i), obs_rd, exp_rd);
            end
        end

        if (busy && cyc == r_cyc) begin
            if (!cur_to && cur.we) ref_mem[cur.addr] = merge(rd_ref(cur.addr), cur.wdata, cur.be);
            pend_v[owner] = 1'b0;
            busy          = 1'b0;
            idle_from     = cyc + 1;
        end

        // memory: ready after cur_lat non-ready WAIT cycles (ISSUE is cycle 1)
        if (mem_req_o === 1'b1) begin
            hi_cnt++;
            if (hi_cnt == cur_lat + 2) begin
                mem_ready_i = 1'b1;
                if (mem_we_o) begin
                    env_mem[mem_addr_o] = merge(rd_env(mem_addr_o), mem_wdata_o, mem_be_o);
                    mem_rdata_i = $urandom;
                end else begin
                    mem_rdata_i = rd_env(mem_addr_o);
                end
            end else begin
                mem_ready_i = 1'b0;
                mem_rdata_i = $urandom;
            end
        end else begin
            hi_cnt      = 0;
            mem_ready_i = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
        end

        if (rst_drive) begin
            rst_i     = 1'b1;
            busy      = 1'b0;
            last      = 1;
            pend_v[0] = 1'b0;
            pend_v[1] = 1'b0;
            idle_from = cyc + 1;
            drive_m(0, 1'b0, rand_txn());
            drive_m(1, 1'b0, rand_txn());
        end else begin
            rst_i = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (!pend_v[i] && int'($urandom_range(0, 99)) < auto_rate) begin
                    pend_v[i] = 1'b1;
                    pend[i]   = rand_txn();
                end else if (pend_v[i] && !(busy && owner == i) &&
                             int'($urandom_range(0, 99)) < withdraw_rate) begin
                    pend_v[i] = 1'b0;
                end
                if (pend_v[i] && busy && owner == i && scramble) drive_m(i, 1'b1, rand_txn());
                else if (pend_v[i])                               drive_m(i, 1'b1, pend[i]);
                else                                              drive_m(i, 1'b0, rand_txn());
            end
            if (!busy && cyc >= idle_from && (pend_v[0] || pend_v[1])) begin
                if (pend_v[0] && pend_v[1]) w = (last == 1) ? 0 : 1;
                else                        w = pend_v[0] ? 0 : 1;
                last    = w;
                busy    = 1'b1;
                owner   = w;
                cur     = pend[w];
                g_cyc   = cyc;
                cur_lat = (lat_force >= 0) ? lat_force : rand_lat();
                cur_to  = (cur_lat >= TO);
                n_wait  = cur_to ? TO : cur_lat + 1;
                r_cyc   = cyc + 2 + n_wait;
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        for (int k = 0; k < budget && (busy || pend_v[0] || pend_v[1]); k++) cycle();
        chk("drain_bound", 32'(busy || pend_v[0] || pend_v[1]), 32'd0);
    endtask

    task automatic clear_obs();
        req_hi_total    = 0;
        last_rdy_cyc[0] = -1; last_rdy_cyc[1] = -1;
        last_rdata[0]   = 32'hx; last_rdata[1] = 32'hx;
        last_err[0]     = 1'bx;  last_err[1]   = 1'bx;
    endtask

    initial begin
        int          n, n_rdy;
        logic [31:0] w20;
        rst_i = 1'b1; mem_ready_i = 1'b0; mem_rdata_i = 32'd0;
        drive_m(0, 1'b0, '0); drive_m(1, 1'b0, '0);
        busy = 1'b0; last = 1; hi_cnt = 0; idle_from = 0; pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        auto_rate = 0; withdraw_rate = 0; lat_force = 0; scramble = 1'b1;
        checks_on = 1'b0; rst_drive = 1'b1;
        clear_obs();

        // reset state
        cycle();
        checks_on = 1'b1;
        cycle();
        rst_drive = 1'b0;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_m0_ready", 32'(m0_ready_o), 32'd0);
        chk("rst_m1_rdata", m1_rdata_o, 32'd0);
        cycle();

        // m0 read, memory ready in first WAIT cycle
        env_mem[32'h10] = 32'h1234_5678; ref_mem[32'h10] = 32'h1234_5678;
        clear_obs(); lat_force = 0; n = cyc + 1; n_rdy = rdy_log.size();
        issue(0, 1'b0, 4'hf, 32'h10, 32'h0);
        run_until_idle(40);
        chk("t1_ready_cycle", 32'(last_rdy_cyc[0]), 32'(n + 3));
        chk("t1_rdata", last_rdata[0], 32'h1234_5678);
        chk("t1_err", 32'(last_err[0]), 32'd0);
        chk("t1_req_cycles", 32'(req_hi_total), 32'd2);
        chk("t1_pulses", 32'(rdy_log.size() - n_rdy), 32'd1);

        // m1 partial write
        clear_obs(); n = cyc + 1; n_rdy = rdy_log.size();
        issue(1, 1'b1, 4'b0011, 32'h20, 32'haabb_ccdd);
        run_until_idle(40);
        w20 = init_word(32'h20);
        chk("t2_ready_cycle", 32'(last_rdy_cyc[1]), 32'(n + 3));
        chk("t2_rdata", last_rdata[1], 32'd0);
        chk("t2_req_cycles", 32'(req_hi_total), 32'd2);
        chk("t2_mem_fields", {seen.we, seen.be, seen.addr, seen.wdata} >> 32, {1'b1, 4'b0011, 32'h20});
        chk("t2_mem_wdata", seen.wdata, 32'haabb_ccdd);
        chk("t2_mem_word", rd_env(32'h20), {w20[31:16], 16'hccdd});
        chk("t2_pulses", 32'(rdy_log.size() - n_rdy), 32'd1);

        // both masters held from reset: strict alternation starting with m0
        rst_drive = 1'b1; cycle(); rst_drive = 1'b0;
        lat_force = -1; auto_rate = 100; n_rdy = rdy_log.size();
        for (int k = 0; k < 400 && rdy_log.size() < n_rdy + 4; k++) cycle();
        auto_rate = 0;
        run_until_idle(200);
        chk("t3_count", 32'(rdy_log.size() >= n_rdy + 4), 32'd1);
        if (rdy_log.size() >= n_rdy + 4) begin
            for (int k = 0; k < 4; k++) chk($sformatf("t3_order%0d", k), 32'(rdy_log[n_rdy + k]), 32'(k % 2));
        end

        // memory never ready: timeout after 16 WAIT cycles
        clear_obs(); lat_force = NEVER; n = cyc + 1;
        issue(0, 1'b0, 4'hf, 32'h14, 32'h0);
        run_until_idle(60);
        chk("t4_ready_cycle", 32'(last_rdy_cyc[0]), 32'(n + 18));
        chk("t4_rdata", last_rdata[0], 32'hdead_beef);
        chk("t4_err", 32'(last_err[0]), 32'd1);
        chk("t4_req_cycles", 32'(req_hi_total), 32'd17);

        // ready in the last allowed WAIT cycle still completes normally
        clear_obs(); lat_force = TO - 1; n = cyc + 1;
        issue(0, 1'b0, 4'hf, 32'h18, 32'h0);
        run_until_idle(60);
        chk("t4b_ready_cycle", 32'(last_rdy_cyc[0]), 32'(n + 18));
        chk("t4b_rdata", last_rdata[0], rd_ref(32'h18));
        chk("t4b_err", 32'(last_err[0]), 32'd0);
        chk("t4b_req_cycles", 32'(req_hi_total), 32'd17);

        // reset during WAIT: access lost, no ready, m0 wins the next tie
        clear_obs(); lat_force = NEVER; n_rdy = rdy_log.size();
        issue(0, 1'b0, 4'hf, 32'h1c, 32'h0);
        cycle(); cycle(); cycle();
        rst_drive = 1'b1; cycle(); rst_drive = 1'b0;
        cycle();
        chk("t5_req_after_rst", 32'(mem_req_o), 32'd0);
        for (int k = 0; k < 5; k++) cycle();
        chk("t5_no_ready", 32'(rdy_log.size() - n_rdy), 32'd0);
        lat_force = 0;
        issue(0, 1'b0, 4'hf, 32'h24, 32'h0);
        issue(1, 1'b0, 4'hf, 32'h28, 32'h0);
        run_until_idle(60);
        chk("t5_count", 32'(rdy_log.size() - n_rdy), 32'd2);
        if (rdy_log.size() > n_rdy) chk("t5_first", 32'(rdy_log[n_rdy]), 32'd0);

        // delayed ready with the master changing its fields after grant
        clear_obs(); lat_force = 3; n = cyc + 1;
        issue(0, 1'b0, 4'hf, 32'h30, 32'h0);
        run_until_idle(40);
        chk("t6_ready_cycle", 32'(last_rdy_cyc[0]), 32'(n + 6));
        chk("t6_addr", seen.addr, 32'h30);
        chk("t6_rdata", last_rdata[0], rd_ref(32'h30));
        chk("t6_req_cycles", 32'(req_hi_total), 32'd5);

        // random traffic with withdrawals and mixed latencies
        lat_force = -1; auto_rate = 30; withdraw_rate = 5;
        for (int k = 0; k < 3000; k++) cycle();
        auto_rate = 0; withdraw_rate = 0;
        run_until_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
